if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage of the 5-stage LoongArch32 pipeline. Generates PC, fetches from inst SRAM (sram-like req/addr_ok/data_ok),
//  drives the {pc,inst} bus and valid to decode, and consumes decode's {br_taken,br_target} redirect bus.
//  At most one outstanding SRAM request; wrong-path returns are cancelled.
// PARAMETERS
//  RESET_PC  32'h1c000000  first fetch address after reset release
// PORTS
//  clk              in   1                 clock
//  resetn           in   1                 asynchronous, active-low reset
//  ds_allowin       in   1                 decode can accept this cycle
//  br_bus           in   `BR_BUS_WD (33)   {br_taken[32], br_target[31:0]}
//  fs_to_ds_valid   out  1                 bus valid to decode
//  fs_to_ds_bus     out  `FS_TO_DS_BUS_WD  {fs_pc[63:32], fs_inst[31:0]}
//  fs_adef          out  1                 fetch-address-error flag travelling with the bus
//  inst_sram_req    out  1                 request valid
//  inst_sram_wr     out  1                 constant 0
//  inst_sram_size   out  2                 constant 2'd2 (word)
//  inst_sram_wstrb  out  4                 constant 4'h0
//  inst_sram_wdata  out  32                constant 0
//  inst_sram_addr   out  32                fetch address, word aligned
//  inst_sram_addr_ok in  1                 request accepted this cycle
//  inst_sram_data_ok in  1                 read data valid this cycle
//  inst_sram_rdata  in   32                read data
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, pf_pc=RESET_PC, fs_valid=0, bus regs=0, cancel=0, br_pend=0, fs_adef=0; req=0.
//  FSM states: IDLE, REQ, WAIT, HOLD.
//   IDLE: -> REQ next cycle unconditionally (first req one cycle after resetn rises).
//   REQ : req=1, addr=pf_pc; addr must stay stable until addr_ok. addr_ok -> WAIT, fs_pc<=pf_pc.
//   WAIT: req=0. data_ok & !cancel & !br_taken -> HOLD, fs_inst<=rdata, fs_valid<=1.
//         data_ok & (cancel|br_taken) -> discard data, -> REQ with pf_pc=redirect target, cancel<=0, br_pend<=0.
//   HOLD: fs_to_ds_valid=fs_valid. fs_valid & ds_allowin -> REQ, pf_pc<=fs_pc+4, fs_valid<=0.
//  Redirect (br_taken=1, target T), priority over sequential flow in every state:
//   REQ, addr_ok=0: br_pend<=1, tgt<=T; request held; on later addr_ok set cancel<=1.
//   REQ, addr_ok=1 same cycle: -> WAIT with cancel<=1, tgt<=T.
//   WAIT: cancel<=1, tgt<=T (or immediate discard if data_ok same cycle, see above).
//   HOLD: fs_valid<=0, pf_pc<=T, -> REQ (held inst dropped even if ds_allowin=1 same cycle).
//   Repeated br_taken cycles: latest T overwrites tgt; idempotent otherwise.
//  data_ok outside WAIT is a protocol error: ignored (sim assertion fires).
//  fs_pc+4 wraps modulo 2^32. Latency: req accept to fs_to_ds_valid = data_ok latency + 1 cycle.
//  Reset asserted mid-transaction: all state cleared immediately; SRAM bridge is reset alongside.
// CONFIGURATION
//  IF_ADEF_EN defined: in REQ, pf_pc[1:0]!=0 -> no req issued; -> HOLD next cycle with fs_inst=32'h0, fs_adef=1,
//   fs_pc=pf_pc; after handoff fetch stays in IDLE until a redirect arrives.
//  IF_ADEF_EN undefined: inst_sram_addr={pf_pc[31:2],2'b00}; fs_adef tied 0.
// STRUCTURE
//  mycpu.vh: FS_TO_DS_BUS_WD, BR_BUS_WD, IF state encodings (IF_IDLE/IF_REQ/IF_WAIT/IF_HOLD), RESET_PC default.
//  One sub-module: if_req_ctrl (FSM + cancel/br_pend/tgt tracking); datapath (pc, inst, bus regs) stays in if_stage.
// TESTING
//  1 reset release, addr_ok=1, data_ok 1 cycle later, rdata=32'h02800421, ds_allowin=1 -> addr 1c000000,
//    bus {1c000000,02800421} valid, next req addr 1c000004.
//  2 ds_allowin=0 for 5 cycles in HOLD -> bus/valid stable, no req; allowin=1 -> next req pc+4.
//  3 br_taken T=1c000100 while WAIT -> returned data dropped, fs_to_ds_valid stays 0, next req addr 1c000100.
//  4 br_taken T=1c000200 in REQ with addr_ok held 0 for 3 cycles -> addr stays 1c000008 until accept,
//    its data dropped, next req 1c000200.
//  5 br_taken with ds_allowin=1 in HOLD -> held inst not re-presented, req at T next cycle.
//  6 IF_ADEF_EN, T=1c000102 -> no req, bus {1c000102,0} valid with fs_adef=1; undefined: req addr 1c000100.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared widths, state encodings and bus payloads for the LoongArch32 fetch stage.
package if_stage_pkg;

  localparam int unsigned BR_BUS_WD       = 33;
  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_req_ctrl.sv
// Fetch request FSM: issues one SRAM request at a time and tracks redirects that
// arrive while a request is in flight (pending branch, cancel of wrong-path data).
module if_req_ctrl
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic        ds_allowin,
  input  logic        pc_misalign,
  output logic        req_c,
  output logic        accept_c,
  output logic        capture_c,
  output logic        adef_c,
  output logic        valid_clr_c,
  output logic        pc_tgt_c,
  output logic        pc_seq_c,
  output logic [31:0] redir_pc_c
);

  if_state_e   state, state_n;
  logic        cancel, cancel_n;
  logic        br_pend, br_pend_n;
  logic        halt, halt_n;
  logic [31:0] tgt, tgt_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IF_IDLE;
      cancel  <= 1'b0;
      br_pend <= 1'b0;
      halt    <= 1'b0;
      tgt     <= '0;
    end else begin
      state   <= state_n;
      cancel  <= cancel_n;
      br_pend <= br_pend_n;
      halt    <= halt_n;
      tgt     <= tgt_n;
    end
  end

  // A live redirect always wins over a previously latched target.
  always_comb begin
    state_n     = state;
    cancel_n    = cancel;
    br_pend_n   = br_pend;
    halt_n      = halt;
    tgt_n       = br_taken ? br_target : tgt;
    req_c       = 1'b0;
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    adef_c      = 1'b0;
    valid_clr_c = 1'b0;
    pc_tgt_c    = 1'b0;
    pc_seq_c    = 1'b0;
    redir_pc_c  = br_taken ? br_target : tgt;

    case (state)
      IF_IDLE: begin
        if (br_taken) begin
          state_n  = IF_REQ;
          pc_tgt_c = 1'b1;
          halt_n   = 1'b0;
        end else if (!halt) begin
          state_n = IF_REQ;
        end
      end
      IF_REQ: begin
        if (pc_misalign) begin
          if (br_taken) begin
            pc_tgt_c = 1'b1;
          end else begin
            state_n = IF_HOLD;
            adef_c  = 1'b1;
            halt_n  = 1'b1;
          end
        end else begin
          req_c = 1'b1;
          if (addr_ok) begin
            state_n   = IF_WAIT;
            accept_c  = 1'b1;
            cancel_n  = br_taken | br_pend;
            br_pend_n = 1'b0;
          end else if (br_taken) begin
            br_pend_n = 1'b1;
          end
        end
      end
      IF_WAIT: begin
        if (data_ok) begin
          if (cancel || br_taken) begin
            state_n   = IF_REQ;
            pc_tgt_c  = 1'b1;
            cancel_n  = 1'b0;
            br_pend_n = 1'b0;
          end else begin
            state_n   = IF_HOLD;
            capture_c = 1'b1;
          end
        end else if (br_taken) begin
          cancel_n = 1'b1;
        end
      end
      IF_HOLD: begin
        if (br_taken) begin
          state_n     = IF_REQ;
          pc_tgt_c    = 1'b1;
          valid_clr_c = 1'b1;
          halt_n      = 1'b0;
        end else if (ds_allowin) begin
          state_n     = halt ? IF_IDLE : IF_REQ;
          pc_seq_c    = 1'b1;
          valid_clr_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read data may only come back while a request is outstanding.
  a_data_ok_in_wait: assert property (@(posedge clk) disable iff (!resetn)
    data_ok |-> (state == IF_WAIT));

endmodule

// File: rtl/if_stage.sv
// LoongArch32 fetch stage: PC generation, inst SRAM fetch and the {pc,inst} bus to decode.
// Define IF_ADEF_EN to raise a fetch-address error on misaligned PCs instead of fetching.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       fs_adef,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_wdata,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  br_bus_t     br;
  fs_to_ds_t   fs_q;
  logic [31:0] pf_pc;
  logic        fs_valid;
  logic        fs_adef_q;
  logic        pc_misalign;
  logic        req_c, accept_c, capture_c, adef_c, valid_clr_c, pc_tgt_c, pc_seq_c;
  logic [31:0] redir_pc_c;

  assign br = br_bus_t'(br_bus);

`ifdef IF_ADEF_EN
  assign pc_misalign = |pf_pc[1:0];
`else
  assign pc_misalign = 1'b0;
`endif

  if_req_ctrl u_req_ctrl (
    .clk         (clk),
    .resetn      (resetn),
    .br_taken    (br.taken),
    .br_target   (br.target),
    .addr_ok     (inst_sram_addr_ok),
    .data_ok     (inst_sram_data_ok),
    .ds_allowin  (ds_allowin),
    .pc_misalign (pc_misalign),
    .req_c       (req_c),
    .accept_c    (accept_c),
    .capture_c   (capture_c),
    .adef_c      (adef_c),
    .valid_clr_c (valid_clr_c),
    .pc_tgt_c    (pc_tgt_c),
    .pc_seq_c    (pc_seq_c),
    .redir_pc_c  (redir_pc_c)
  );

  // Fetch PC, the bus to decode and its valid/adef flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pf_pc     <= RESET_PC;
      fs_q      <= '0;
      fs_valid  <= 1'b0;
      fs_adef_q <= 1'b0;
    end else begin
      if (pc_tgt_c) begin
        pf_pc <= redir_pc_c;
      end else if (pc_seq_c) begin
        pf_pc <= fs_q.pc + 32'd4;
      end
      if (accept_c || adef_c) begin
        fs_q.pc <= pf_pc;
      end
      if (capture_c) begin
        fs_q.inst <= inst_sram_rdata;
      end else if (adef_c) begin
        fs_q.inst <= '0;
      end
      if (capture_c || adef_c) begin
        fs_valid <= 1'b1;
      end else if (valid_clr_c) begin
        fs_valid <= 1'b0;
      end
      if (adef_c) begin
        fs_adef_q <= 1'b1;
      end else if (capture_c || valid_clr_c) begin
        fs_adef_q <= 1'b0;
      end
    end
  end

  assign fs_to_ds_valid  = fs_valid;
  assign fs_to_ds_bus    = FS_TO_DS_BUS_WD'(fs_q);
  assign fs_adef         = fs_adef_q;
  assign inst_sram_req   = req_c;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = word_addr(pf_pc);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch handshake, decode stall, redirects in every
// state, PC wrap, misaligned fetch (IF_ADEF_EN aware) and mid-transaction reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ds_allowin = 1'b1;
  logic [32:0] br_bus = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        fs_adef;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .fs_adef           (fs_adef),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({inst_sram_req, fs_to_ds_valid, fs_adef} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000", {inst_sram_req, fs_to_ds_valid, fs_adef});
    end
    checks++;
    if (fs_to_ds_bus !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h exp 0", fs_to_ds_bus);
    end
    checks++;
    if (inst_sram_addr !== 32'h1c000000) begin
      errors++;
      $display("FAIL reset_addr: got %h exp 1c000000", inst_sram_addr);
    end
    checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'd2, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL sram_consts: wr %b size %0d wstrb %h wdata %h", inst_sram_wr, inst_sram_size,
               inst_sram_wstrb, inst_sram_wdata);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (inst_sram_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got %b exp 0", inst_sram_req);
    end
    tick();
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h1c000000}) begin
      errors++;
      $display("FAIL first_req: got req %b addr %h exp 1 1c000000", inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_basic_fetch();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    checks++;
    if ({inst_sram_req, fs_to_ds_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wait_quiet: got req %b valid %b exp 0 0", inst_sram_req, fs_to_ds_valid);
    end
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h02800421;
    tick();
    inst_sram_data_ok = 1'b0;
    checks++;
    if ({fs_to_ds_valid, fs_to_ds_bus} !== {1'b1, 32'h1c000000, 32'h02800421}) begin
      errors++;
      $display("FAIL first_bus: got valid %b bus %h exp 1 1c00000002800421", fs_to_ds_valid, fs_to_ds_bus);
    end
    tick();
    checks++;
    if ({inst_sram_req, inst_sram_addr, fs_to_ds_valid} !== {1'b1, 32'h1c000004, 1'b0}) begin
      errors++;
      $display("FAIL next_req: got req %b addr %h valid %b exp 1 1c000004 0",
               inst_sram_req, inst_sram_addr, fs_to_ds_valid);
    end
  endtask

  task automatic test_stall();
    ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h00150004;
    tick();
    inst_sram_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({fs_to_ds_valid, inst_sram_req, fs_to_ds_bus} !== {1'b1, 1'b0, 32'h1c000004, 32'h00150004}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid %b req %b bus %h exp 1 0 1c00000400150004",
                 i, fs_to_ds_valid, inst_sram_req, fs_to_ds_bus);
      end
      tick();
    end
    ds_allowin = 1'b1;
    tick();
    checks++;
    if ({inst_sram_req, inst_sram_addr, fs_to_ds_valid} !== {1'b1, 32'h1c000008, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: got req %b addr %h valid %b exp 1 1c000008 0",
               inst_sram_req, inst_sram_addr, fs_to_ds_valid);
    end
  endtask

  task automatic test_redirect_in_req();
    br_bus = {1'b1, 32'h1c000200};
    tick();
    br_bus = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h1c000008}) begin
        errors++;
        $display("FAIL req_held[%0d]: got req %b addr %h exp 1 1c000008", i, inst_sram_req, inst_sram_addr);
      end
      tick();
    end
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h1c000008}) begin
      errors++;
      $display("FAIL req_held_last: got req %b addr %h exp 1 1c000008", inst_sram_req, inst_sram_addr);
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hdeadbeef;
    tick();
    inst_sram_data_ok = 1'b0;
    checks++;
    if ({fs_to_ds_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000200}) begin
      errors++;
      $display("FAIL req_redirect: got valid %b req %b addr %h exp 0 1 1c000200",
               fs_to_ds_valid, inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_redirect_in_wait();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    br_bus = {1'b1, 32'h1c000100};
    tick();
    br_bus = '0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h11111111;
    tick();
    inst_sram_data_ok = 1'b0;
    checks++;
    if ({fs_to_ds_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000100}) begin
      errors++;
      $display("FAIL wait_redirect: got valid %b req %b addr %h exp 0 1 1c000100",
               fs_to_ds_valid, inst_sram_req, inst_sram_addr);
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    br_bus = {1'b1, 32'h1c000300};
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h22222222;
    tick();
    br_bus = '0;
    inst_sram_data_ok = 1'b0;
    checks++;
    if ({fs_to_ds_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000300}) begin
      errors++;
      $display("FAIL data_redirect: got valid %b req %b addr %h exp 0 1 1c000300",
               fs_to_ds_valid, inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_redirect_in_hold();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h33333333;
    tick();
    inst_sram_data_ok = 1'b0;
    checks++;
    if ({fs_to_ds_valid, fs_to_ds_bus} !== {1'b1, 32'h1c000300, 32'h33333333}) begin
      errors++;
      $display("FAIL hold_bus: got valid %b bus %h exp 1 1c00030033333333", fs_to_ds_valid, fs_to_ds_bus);
    end
    br_bus = {1'b1, 32'h1c000400};
    tick();
    br_bus = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({fs_to_ds_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000400}) begin
        errors++;
        $display("FAIL hold_redirect[%0d]: got valid %b req %b addr %h exp 0 1 1c000400",
                 i, fs_to_ds_valid, inst_sram_req, inst_sram_addr);
      end
      tick();
    end
  endtask

  task automatic test_pc_wrap();
    ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h44444444;
    tick();
    inst_sram_data_ok = 1'b0;
    br_bus = {1'b1, 32'hfffffffc};
    tick();
    br_bus = '0;
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hfffffffc}) begin
      errors++;
      $display("FAIL wrap_req: got req %b addr %h exp 1 fffffffc", inst_sram_req, inst_sram_addr);
    end
    ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h55555555;
    tick();
    inst_sram_data_ok = 1'b0;
    checks++;
    if ({fs_to_ds_valid, fs_to_ds_bus} !== {1'b1, 32'hfffffffc, 32'h55555555}) begin
      errors++;
      $display("FAIL wrap_bus: got valid %b bus %h exp 1 fffffffc55555555", fs_to_ds_valid, fs_to_ds_bus);
    end
    tick();
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h00000000}) begin
      errors++;
      $display("FAIL wrap_next: got req %b addr %h exp 1 00000000", inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_misaligned();
    ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h66666666;
    tick();
    inst_sram_data_ok = 1'b0;
    br_bus = {1'b1, 32'h1c000102};
    tick();
    br_bus = '0;
`ifdef IF_ADEF_EN
    checks++;
    if ({inst_sram_req, fs_to_ds_valid} !== 2'b00) begin
      errors++;
      $display("FAIL adef_no_req: got req %b valid %b exp 0 0", inst_sram_req, fs_to_ds_valid);
    end
    tick();
    checks++;
    if ({fs_to_ds_valid, fs_adef, inst_sram_req, fs_to_ds_bus} !== {3'b110, 32'h1c000102, 32'h0}) begin
      errors++;
      $display("FAIL adef_bus: got valid %b adef %b req %b bus %h exp 1 1 0 1c00010200000000",
               fs_to_ds_valid, fs_adef, inst_sram_req, fs_to_ds_bus);
    end
    ds_allowin = 1'b1;
    tick();
    tick();
    checks++;
    if ({fs_to_ds_valid, fs_adef, inst_sram_req} !== 3'b000) begin
      errors++;
      $display("FAIL adef_halt: got valid %b adef %b req %b exp 0 0 0", fs_to_ds_valid, fs_adef, inst_sram_req);
    end
    br_bus = {1'b1, 32'h1c000000};
    tick();
    br_bus = '0;
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h1c000000}) begin
      errors++;
      $display("FAIL adef_resume: got req %b addr %h exp 1 1c000000", inst_sram_req, inst_sram_addr);
    end
`else
    ds_allowin = 1'b1;
    checks++;
    if ({inst_sram_req, inst_sram_addr, fs_adef} !== {1'b1, 32'h1c000100, 1'b0}) begin
      errors++;
      $display("FAIL misalign_req: got req %b addr %h adef %b exp 1 1c000100 0",
               inst_sram_req, inst_sram_addr, fs_adef);
    end
`endif
  endtask

  task automatic test_reset_mid();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if ({inst_sram_req, fs_to_ds_valid, inst_sram_addr, fs_to_ds_bus} !== {2'b00, 32'h1c000000, 64'h0}) begin
      errors++;
      $display("FAIL mid_reset: got req %b valid %b addr %h bus %h exp 0 0 1c000000 0",
               inst_sram_req, fs_to_ds_valid, inst_sram_addr, fs_to_ds_bus);
    end
    tick();
    resetn = 1'b1;
    tick();
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h1c000000}) begin
      errors++;
      $display("FAIL mid_reset_restart: got req %b addr %h exp 1 1c000000", inst_sram_req, inst_sram_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_in_req();
    test_redirect_in_wait();
    test_redirect_in_hold();
    test_pc_wrap();
    test_misaligned();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
